sha256_msg_padder: RTL and testbench
====================================

SHA256_MSG_PADDER -- requirements
Module: sha256_msg_padder

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by SHA-256.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  a byte beat is offered.
REQ-005 in_ready  output  1  the beat is accepted when in_valid && in_ready.
REQ-006 in_byte  input  8  message byte, in message order.
REQ-007 in_bvalid  input  1  in_byte carries data; 0 is legal only with in_last (empty terminator).
REQ-008 in_last  input  1  final beat of the message.
REQ-009 blk_valid  output  1  blk_data holds a complete padded 512-bit block.
REQ-010 blk_ready  input  1  the block is consumed when blk_valid && blk_ready.
REQ-011 blk_data  output  512  padded block; byte 0 (first message byte) in bits 511:504, i.e. bit 0 of the core's [0:511] message port.
REQ-012 blk_first  output  1  this is the first block of the message (the core loads the initial hash).
REQ-013 blk_last  output  1  this is the final block of the message (the length field is present).

Function
REQ-014 The block SHALL implement the states FILL, HOLD and EXTRA.
REQ-015 FILL: in_ready=1; each accepted beat with in_bvalid=1 SHALL write in_byte at byte index idx (0..63), increment idx and add 8 to the 64-bit bit counter (modulo 2^64).
REQ-016 A beat with in_bvalid=0 and in_last=0 SHALL be accepted with no effect.
REQ-017 If the accepted byte makes idx=64 and in_last=0, the block SHALL go to HOLD with blk_valid=1 and blk_last=0 on the next cycle.
REQ-018 On an accepted in_last beat, let n be the final idx (0..64). If n<=55, the block SHALL insert 0x80 at byte n, zero bytes n+1..55, place the bit count big-endian in bytes 56..63, and go to HOLD with blk_last=1.
REQ-019 On an accepted in_last beat with 56<=n<=63, the block SHALL insert 0x80 at byte n, zero the rest, go to HOLD with blk_last=0, and set the extra-block pending flag.
REQ-020 On an accepted in_last beat with n=64, the block SHALL emit the data block (blk_last=0) and set the pending flag with the 0x80-needed flag set.
REQ-021 Padding SHALL be formed in the same clock edge that accepts the beat; blk_valid asserts exactly 1 cycle after the completing beat is accepted.
REQ-022 HOLD: in_ready=0; blk_data, blk_first and blk_last SHALL stay stable while blk_valid && !blk_ready.
REQ-023 On a HOLD handshake with pending set, the block SHALL go to EXTRA.
REQ-024 On a HOLD handshake without pending, the block SHALL clear idx to 0 and return to FILL; if blk_last was 1, it SHALL also clear the bit counter and set the first flag.
REQ-025 EXTRA: in_ready=0; the block SHALL present a block of zeros, with byte 0=0x80 if 0x80-needed is set, and the bit count in bytes 56..63, with blk_valid=1 and blk_last=1 on the cycle after entering EXTRA.
REQ-026 The EXTRA handshake SHALL behave as REQ-024 with blk_last=1.
REQ-027 blk_first SHALL be 1 on the first block after reset or after any block with blk_last=1, and 0 otherwise.
REQ-028 A simultaneous in_valid and blk_handshake cannot occur (in_ready=0 in HOLD/EXTRA); the block SHALL NOT accept input and emit in the same cycle.

Reset
REQ-029 Reset SHALL force FILL, idx=0, bit count=0, pending=0, first flag=1, in_ready=1, blk_valid=0, blk_first=0, blk_last=0 and blk_data=0.
REQ-030 Reset mid-message or mid-HOLD SHALL discard all partial data; the next accepted byte SHALL start a new message.

Structure
REQ-031 The shared SHA package SHALL hold the block size constants (64 bytes, length offset 56) and the state enumeration.
REQ-032 A single sub-module sha256_pad_insert SHALL be instantiated: a combinational unit taking the buffer, n, the bit count and flags, and producing the padded block.

Verification
REQ-033 Message "projectfpga.com" (15 bytes) -> one block 0x70726f6a656374667067612e636f6d80, then zeros, with the low 64 bits = 0x78; first=last=1.
REQ-034 Message "abc" -> one block 0x61626380, zeros, length 0x18; fed to the core -> digest ba7816bf...f20015ad.
REQ-035 56-byte message -> block 1 with byte 56=0x80 and last=0, then block 2 all zeros with length 0x1C0 and last=1.
REQ-036 64-byte message -> data block (last=0), then a block with byte 0=0x80 and length 0x200; empty message (in_bvalid=0, in_last=1) -> 0x80, zeros, length 0.
REQ-037 blk_ready held low 10 cycles -> blk_data stable and in_ready=0; reset asserted after 20 bytes -> next 3-byte message produces the correct single block with first=1.

Source files
------------

// File: rtl/sha256_msg_padder_pkg.sv
// sha256_msg_padder_pkg: SHA-256 block geometry and padder state encoding
package sha256_msg_padder_pkg;
  localparam logic [6:0] BLK_BYTES = 7'd64;
  localparam logic [6:0] LEN_OFF = 7'd56;
  typedef enum logic [1:0] {FILL, HOLD, EXTRA} state_t;
endpackage

// File: rtl/sha256_pad_insert.sv
// sha256_pad_insert: combinational 0x80 marker, zero fill and big-endian length insertion
module sha256_pad_insert
  import sha256_msg_padder_pkg::*;
(
  input  logic [511:0] blk_in,
  input  logic [6:0]   n,
  input  logic [63:0]  bit_cnt,
  input  logic         pad_en,
  input  logic         len_en,
  output logic [511:0] blk_out
);
  for (genvar i = 0; i < 64; i++) begin : g_byte
    logic [7:0] d;
    logic [7:0] p;
    assign d = blk_in[511-8*i -: 8];
    assign p = (!pad_en || 7'(i) < n) ? d : (7'(i) == n) ? 8'h80 : 8'h00;
    if (i >= int'(LEN_OFF)) begin : g_len
      assign blk_out[511-8*i -: 8] = len_en ? bit_cnt[63-8*(i-int'(LEN_OFF)) -: 8] : p;
    end else begin : g_dat
      assign blk_out[511-8*i -: 8] = p;
    end
  end
endmodule

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: packs a byte stream into padded 512-bit SHA-256 blocks
module sha256_msg_padder
  import sha256_msg_padder_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         in_bvalid,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);
  state_t       state;
  logic [6:0]   idx, n_w, pad_n;
  logic [63:0]  bit_cnt, cnt_w, pad_cnt;
  logic         pending, need80, first_flag, done, pad_en, len_en;
  logic [511:0] buf_w, pad_in, pad_out;
  // blk_data doubles as the fill buffer; padding is applied on the completing beat
  always_comb begin
    n_w = idx + {6'd0, in_bvalid};
    cnt_w = bit_cnt + (in_bvalid ? 64'd8 : 64'd0);
    buf_w = blk_data;
    for (int k = 0; k < 64; k++) if (in_bvalid && idx == 7'(k)) buf_w[511-8*k -: 8] = in_byte;
    done = in_last || n_w == BLK_BYTES;
    pad_in = state == EXTRA ? '0 : buf_w;
    pad_n = state == EXTRA ? (need80 ? 7'd0 : BLK_BYTES) : n_w;
    pad_cnt = state == EXTRA ? bit_cnt : cnt_w;
    pad_en = state == EXTRA || (in_last && n_w < BLK_BYTES);
    len_en = state == EXTRA || (in_last && n_w < LEN_OFF);
  end
  sha256_pad_insert u_pad (
    .blk_in (pad_in),
    .n      (pad_n),
    .bit_cnt(pad_cnt),
    .pad_en (pad_en),
    .len_en (len_en),
    .blk_out(pad_out)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
      idx <= '0;
      bit_cnt <= '0;
      pending <= 1'b0;
      need80 <= 1'b0;
      first_flag <= 1'b1;
      in_ready <= 1'b1;
      blk_valid <= 1'b0;
      blk_first <= 1'b0;
      blk_last <= 1'b0;
      blk_data <= '0;
    end else begin
      case (state)
        FILL: if (in_valid && in_ready) begin
          blk_data <= pad_out;
          idx <= n_w;
          bit_cnt <= cnt_w;
          if (done) begin
            state <= HOLD;
            in_ready <= 1'b0;
            blk_valid <= 1'b1;
            blk_first <= first_flag;
            first_flag <= 1'b0;
            blk_last <= len_en;
            pending <= in_last && n_w >= LEN_OFF;
            need80 <= in_last && n_w == BLK_BYTES;
          end
        end
        HOLD: if (blk_valid && blk_ready) begin
          blk_valid <= 1'b0;
          if (pending) begin
            state <= EXTRA;
            pending <= 1'b0;
          end else begin
            state <= FILL;
            in_ready <= 1'b1;
            idx <= '0;
            if (blk_last) begin
              bit_cnt <= '0;
              first_flag <= 1'b1;
            end
          end
        end
        EXTRA: if (!blk_valid) begin
          blk_data <= pad_out;
          blk_valid <= 1'b1;
          blk_first <= 1'b0;
          blk_last <= 1'b1;
        end else if (blk_ready) begin
          blk_valid <= 1'b0;
          state <= FILL;
          in_ready <= 1'b1;
          idx <= '0;
          bit_cnt <= '0;
          first_flag <= 1'b1;
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: directed message vectors against hand-computed padded blocks
module tb_sha256_msg_padder;
  logic         clk = 1'b0, reset = 1'b1;
  logic         in_valid = 1'b0, in_bvalid = 1'b0, in_last = 1'b0, blk_ready = 1'b0;
  logic [7:0]   in_byte = 8'h00;
  logic         in_ready, blk_valid, blk_first, blk_last;
  logic [511:0] blk_data;
  int           n_cmp = 0, n_bad = 0;
  logic [7:0]   msg[$];
  logic [511:0] e;

  sha256_msg_padder dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_byte  (in_byte),
    .in_bvalid(in_bvalid),
    .in_last  (in_last),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .blk_data (blk_data),
    .blk_first(blk_first),
    .blk_last (blk_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [7:0] b, input logic bv, input logic ls);
    in_valid = 1'b1;
    in_byte = b;
    in_bvalid = bv;
    in_last = ls;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bvalid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic set_str(input string s);
    msg.delete();
    for (int k = 0; k < s.len(); k++) msg.push_back(s[k]);
  endtask

  task automatic set_cnt(input int len);
    msg.delete();
    for (int k = 0; k < len; k++) msg.push_back(8'(k));
  endtask

  task automatic feed(input string tag, input int nul_at);
    check({tag, "_rdy"}, in_ready, 1);
    if (msg.size() == 0) beat(8'h00, 1'b0, 1'b1);
    else for (int k = 0; k < msg.size(); k++) begin
      if (k == nul_at) beat(8'hff, 1'b0, 1'b0);
      beat(msg[k], 1'b1, k == msg.size() - 1);
    end
    check({tag, "_lat"}, blk_valid, 1);
  endtask

  task automatic take(input string tag, input logic [511:0] exp, input logic f, input logic l, input int stall);
    int t = 0;
    while (!blk_valid && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({tag, "_valid"}, blk_valid, 1);
    for (int s = 0; s < stall; s++) begin
      check({tag, "_hold"}, blk_data, exp);
      check({tag, "_rdy0"}, in_ready, 0);
      @(posedge clk);
      #1;
    end
    check({tag, "_data"}, blk_data, exp);
    check({tag, "_first"}, blk_first, f);
    check({tag, "_last"}, blk_last, l);
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    check({tag, "_done"}, blk_valid, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", in_ready, 1);
    check("rst_valid", blk_valid, 0);
    check("rst_data", blk_data, 0);
    check("rst_first", blk_first, 0);
    check("rst_last", blk_last, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    set_str("projectfpga.com");
    feed("pfc", -1);
    take("pfc", {128'h70726f6a656374667067612e636f6d80, 320'h0, 64'h78}, 1'b1, 1'b1, 10);

    set_str("abc");
    feed("abc", 1);
    take("abc", {32'h61626380, 416'h0, 64'h18}, 1'b1, 1'b1, 0);

    set_cnt(56);
    feed("m56", -1);
    e = '0;
    for (int k = 0; k < 56; k++) e[511-8*k -: 8] = 8'(k);
    e[511-8*56 -: 8] = 8'h80;
    take("m56a", e, 1'b1, 1'b0, 0);
    take("m56b", {448'h0, 64'h1c0}, 1'b0, 1'b1, 0);

    set_cnt(64);
    feed("m64", -1);
    e = '0;
    for (int k = 0; k < 64; k++) e[511-8*k -: 8] = 8'(k);
    take("m64a", e, 1'b1, 1'b0, 0);
    take("m64b", {8'h80, 440'h0, 64'h200}, 1'b0, 1'b1, 0);

    msg.delete();
    feed("empty", -1);
    take("empty", {8'h80, 440'h0, 64'h0}, 1'b1, 1'b1, 0);

    for (int k = 0; k < 20; k++) beat(8'h55, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("mrst_valid", blk_valid, 0);
    check("mrst_data", blk_data, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    set_str("xyz");
    feed("xyz", -1);
    take("xyz", {32'h78797a80, 416'h0, 64'h18}, 1'b1, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
